// File: rtl/spi_master_fe_if.sv
// ---------------------------------------------------------------------------
// spi_master_fe_if
//   Bundles the host-side handshake and the SPI pad signals of the SPI master
//   front end, so the block and its environment connect through one port.
//
//   Host side : start, data_in (to master), data_out, busy, done (from master)
//   Pad side  : sclk, ss, mosi (from master), miso (to master)
//   Debug     : dbg_state (current FSM state of the master)
//
//   Handshake: start is a level request, accepted on any clock edge where the
//   master is idle; data_in is captured on that same edge.  busy is high from
//   the cycle after acceptance until the done cycle (exclusive); done is a
//   single-cycle pulse in which data_out already holds the received word.
//
//   Modports:
//     master : the SPI master front end itself
//     slave  : the environment driving it (host logic plus the SPI pads)
// ---------------------------------------------------------------------------
interface spi_master_fe_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              ss;
  logic              mosi;
  logic              miso;
  logic [1:0]        dbg_state;

  modport master (
    input  start, data_in, miso,
    output data_out, busy, done, sclk, ss, mosi, dbg_state
  );

  modport slave (
    output start, data_in, miso,
    input  data_out, busy, done, sclk, ss, mosi, dbg_state
  );
endinterface

// File: rtl/spi_master_fe.sv
// ---------------------------------------------------------------------------
// spi_master_fe
//   SPI master front end, mode 0 (CPOL=0): mosi changes on the sclk fall, the
//   slave samples on the rise.  One word per ss-low frame.
//
//   Frame timing (cycle 0 = the cycle start is accepted in IDLE):
//     cycle 1                      : ss=0, busy=1, mosi=first bit
//     LEAD   CLK_DIV cycles        : sclk low (mosi setup)
//     SHIFT  DATA_W sclk periods   : rise at 1+CLK_DIV+2k*CLK_DIV, fall
//                                    CLK_DIV cycles later
//     TRAIL  CLK_DIV cycles        : ss still low, sclk low
//     cycle 1+(2*DATA_W+1)*CLK_DIV : ss=1, done=1, busy=0, data_out valid
//
//   Parameters:
//     DATA_W  : word width in bits (>=2)
//     CLK_DIV : sclk half-period in clk cycles (>=4)
//
//   Ports:
//     clk : system clock, all logic on posedge
//     rst : asynchronous, active-low reset
//     bus : spi_master_fe_if.master (start, data_in, data_out, busy, done,
//           sclk, ss, mosi, miso, dbg_state)
//
//   Build option:
//     SPI_MASTER_LSB_FIRST_EN : when defined, bit 0 is sent and received
//     first.  Default (undefined) is MSB first.  Frame timing is the same.
// ---------------------------------------------------------------------------
module spi_master_fe #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_fe_if.master   bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_TRAIL = 2'd3
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_tx_sr;
  logic [DATA_W-1:0] r_rx_sr;
  logic [DATA_W-1:0] r_data_out;
  logic              r_sclk;
  logic              r_ss;
  logic              r_busy;
  logic              r_done;
  logic              r_miso_s1;
  logic              r_miso_s2;

  logic              w_div_last;
  logic              w_bit_last;
  logic [DATA_W-1:0] w_tx_next;
  logic [DATA_W-1:0] w_rx_next;
  logic              w_mosi;

  assign w_div_last = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_bit_last = (r_bit_cnt == BIT_W'(DATA_W - 1));

  // mosi comes straight off the end of the transmit shift register: loading
  // the word puts the first bit out in cycle 1, each non-final fall shifts
  // the next bit into place, and clearing the register at frame end returns
  // mosi to 0 in IDLE.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_tx_next = {1'b0, r_tx_sr[DATA_W-1:1]};
  assign w_rx_next = {r_miso_s2, r_rx_sr[DATA_W-1:1]};
  assign w_mosi    = r_tx_sr[0];
`else
  assign w_tx_next = {r_tx_sr[DATA_W-2:0], 1'b0};
  assign w_rx_next = {r_rx_sr[DATA_W-2:0], r_miso_s2};
  assign w_mosi    = r_tx_sr[DATA_W-1];
`endif

  // miso is asynchronous to clk; two flops before it is used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= bus.miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_tx_sr    <= '0;
      r_rx_sr    <= '0;
      r_data_out <= '0;
      r_sclk     <= 1'b0;
      r_ss       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_tx_sr   <= bus.data_in;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_ss      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_LEAD;
          end
        end

        S_LEAD: begin
          if (w_div_last) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b1;
            r_state   <= S_SHIFT;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        S_SHIFT: begin
          if (w_div_last) begin
            r_div_cnt <= '0;
            if (r_sclk) begin
              // Falling edge: capture the bit the slave presented, then
              // either advance mosi or leave the last bit standing.
              r_sclk  <= 1'b0;
              r_rx_sr <= w_rx_next;
              if (w_bit_last) begin
                r_state <= S_TRAIL;
              end else begin
                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                r_tx_sr   <= w_tx_next;
              end
            end else begin
              r_sclk <= 1'b1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        S_TRAIL: begin
          if (w_div_last) begin
            r_div_cnt  <= '0;
            r_tx_sr    <= '0;
            r_ss       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_data_out <= r_rx_sr;
            r_state    <= S_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sclk      = r_sclk;
  assign bus.ss        = r_ss;
  assign bus.mosi      = w_mosi;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_spi_master_fe.sv
// ---------------------------------------------------------------------------
// tb_spi_master_fe
//   Self-checking bench for spi_master_fe with DATA_W=8, CLK_DIV=4.
//   Inputs are driven and outputs sampled on the falling clock edge.
//   miso source: 0 = tied low, 1 = loopback of mosi delayed 3 clk, 2 = tied high.
// ---------------------------------------------------------------------------
module tb_spi_master_fe;
  localparam int DW = 8;
  localparam int CD = 4;
  localparam int DONE_CYC = 1 + (2 * DW + 1) * CD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_master_fe_if #(.DATA_W(DW)) bus ();

  spi_master_fe #(.DATA_W(DW), .CLK_DIV(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         miso_mode = 0;
  logic [2:0] lb_dly = 3'b000;
  always @(posedge clk) lb_dly <= {lb_dly[1:0], bus.mosi};
  assign bus.miso = (miso_mode == 1) ? lb_dly[2] : (miso_mode == 2);

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_dout = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver: one complete frame ----------------
  task automatic run_frame(input string tag, input logic [DW-1:0] din, input int mode,
                           input logic [DW-1:0] exp_rise, input logic [DW-1:0] exp_dout);
    int        cyc;
    int        rises;
    int        done_cyc;
    logic      prev_sclk;
    logic      rise_ok;
    logic      ss_sclk_bad;
    logic [DW-1:0] rise_bits;
    logic [DW-1:0] exp_v;
    bus.data_in = din;
    bus.start   = 1'b1;
    miso_mode   = mode;
    exp_q.push_back(exp_dout);
    @(posedge clk);              // edge closing cycle 0
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = ~din;          // must not affect the frame in flight
    cyc = 1;
    check({tag, "_ss_c1"},   bus.ss,   1'b0);
    check({tag, "_busy_c1"}, bus.busy, 1'b1);
    check({tag, "_dout_stable"}, bus.data_out, last_dout);
    rises = 0; done_cyc = -1; prev_sclk = 1'b0; rise_ok = 1'b1; ss_sclk_bad = 1'b0;
    rise_bits = '0;
    while (done_cyc < 0 && cyc < 200) begin
      if (bus.sclk && !prev_sclk) begin
        if (rises < DW) begin
          rise_bits[DW-1-rises] = bus.mosi;
          if (cyc != 1 + CD + 2 * CD * rises) rise_ok = 1'b0;
        end
        rises++;
      end
      if (bus.ss && bus.sclk) ss_sclk_bad = 1'b1;
      prev_sclk = bus.sclk;
      if (bus.done) begin
        done_cyc = cyc;
        exp_v = exp_q.pop_front();
        check({tag, "_data_out"}, bus.data_out, exp_v);
        check({tag, "_busy_done"}, bus.busy, 1'b0);
        check({tag, "_ss_done"},   bus.ss,   1'b1);
        last_dout = exp_v;
      end else begin
        tick();
        cyc++;
      end
    end
    if (done_cyc < 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    check({tag, "_done_cycle"}, done_cyc, DONE_CYC);
    check({tag, "_rise_count"}, rises, DW);
    check({tag, "_rise_timing"}, rise_ok, 1'b1);
    check({tag, "_mosi_bits"}, rise_bits, exp_rise);
    check({tag, "_sclk_while_ss_high"}, ss_sclk_bad, 1'b0);
    tick();
    check({tag, "_done_single"}, bus.done, 1'b0);
    check({tag, "_mosi_idle"},   bus.mosi, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] din;
    int            mode;
    logic [DW-1:0] rise_msb;   // mosi at successive rises, first rise in bit 7
    logic [DW-1:0] rise_lsb;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    int   frames, dones, high_run, gap, d1, d2;
    logic prev_ss, ss_low_seen, done_seen;
    logic [DW-1:0] exp_v;
    logic [DW-1:0] rise_sel;

    vecs[0] = '{din: 8'hA5, mode: 0, rise_msb: 8'hA5, rise_lsb: 8'hA5, dout: 8'h00};
    vecs[1] = '{din: 8'h3C, mode: 1, rise_msb: 8'h3C, rise_lsb: 8'h3C, dout: 8'h3C};
    vecs[2] = '{din: 8'h3C, mode: 0, rise_msb: 8'h3C, rise_lsb: 8'h3C, dout: 8'h00};
    vecs[3] = '{din: 8'h01, mode: 1, rise_msb: 8'h01, rise_lsb: 8'h80, dout: 8'h01};
    vecs[4] = '{din: 8'hC6, mode: 2, rise_msb: 8'hC6, rise_lsb: 8'h63, dout: 8'hFF};

    // ---- reset held with start asserted ----
    bus.start   = 1'b1;
    bus.data_in = 8'hA5;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss",   bus.ss,   1'b1);
    check("rst_sclk", bus.sclk, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_dout", bus.data_out, 8'h00);
    check("rst_mosi", bus.mosi, 1'b0);
    check("rst_state", bus.dbg_state, 2'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ss_low_seen = 1'b0;
    repeat (10) begin
      tick();
      if (!bus.ss || bus.done) ss_low_seen = 1'b1;
    end
    check("post_rst_no_frame", ss_low_seen, 1'b0);

    // ---- table-driven frames ----
    for (int i = 0; i < 5; i++) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
      rise_sel = vecs[i].rise_lsb;
`else
      rise_sel = vecs[i].rise_msb;
`endif
      run_frame($sformatf("vec%0d", i), vecs[i].din, vecs[i].mode, rise_sel, vecs[i].dout);
      repeat (2) tick();
    end

    // ---- start held high: back-to-back frames, extra start ignored ----
    bus.data_in = 8'h01;
    bus.start   = 1'b1;
    miso_mode   = 1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    frames = 0; dones = 0; high_run = 0; gap = -1; d1 = -1; d2 = -1;
    prev_ss = 1'b1;
    for (int c = 1; c <= 170; c++) begin
      tick();
      if (prev_ss && !bus.ss) begin
        frames++;
        if (frames == 1) bus.data_in = 8'h80;
        if (frames == 2) begin
          gap = high_run;
          bus.start = 1'b0;
        end
      end
      if (bus.ss) high_run++;
      else high_run = 0;
      if (bus.done) begin
        dones++;
        if (dones == 1) d1 = c;
        if (dones == 2) d2 = c;
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          check($sformatf("b2b_dout%0d", dones), bus.data_out, exp_v);
          last_dout = exp_v;
        end
      end
      prev_ss = bus.ss;
    end
    while (exp_q.size() > 0) void'(exp_q.pop_front());
    check("b2b_frames", frames, 2);
    check("b2b_dones",  dones,  2);
    check("b2b_ss_gap", gap,    1);
    check("b2b_done1_cycle", d1, DONE_CYC);
    check("b2b_done2_cycle", d2, 2 * DONE_CYC);

    // ---- reset in the middle of a frame ----
    repeat (3) tick();
    bus.data_in = 8'hA5;
    bus.start   = 1'b1;
    miso_mode   = 1;
    tick();
    bus.start = 1'b0;
    repeat (29) tick();           // now at cycle 30
    rst = 1'b0;
    #1;
    check("midrst_ss",   bus.ss,   1'b1);
    check("midrst_sclk", bus.sclk, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_dout", bus.data_out, 8'h00);
    last_dout = '0;
    @(negedge clk);
    rst = 1'b1;
    done_seen = 1'b0;
    repeat (80) begin
      tick();
      if (bus.done || !bus.ss) done_seen = 1'b1;
    end
    check("midrst_no_done", done_seen, 1'b0);
    run_frame("after_rst", 8'h3C, 1, 8'h3C, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
